// File: rtl/parking_route_sequencer.sv
// Parking guidance sequencer: a writable per-slot route table, walked hop by hop on a
// handshaked request, lighting one junction lamp per hop for DWELL cycles.
module parking_route_sequencer #(
  parameter int NUM_SLOTS = 8,
  parameter int NUM_JUNC  = 4,
  parameter int MAX_HOPS  = 4,
  parameter int DWELL     = 16,
  localparam int SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int JW  = (NUM_JUNC > 1) ? $clog2(NUM_JUNC) : 1,
  localparam int HW  = JW + 2,
  localparam int PW  = MAX_HOPS * HW,
  localparam int LW  = 4 * NUM_JUNC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_slot,
  input  logic [PW-1:0] cfg_path,
  input  logic          req_valid,
  input  logic [SW-1:0] req_slot,
  output logic          req_ready,
  input  logic          cancel,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] lamps
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1;
  // req_ready depends only on state, never on req_valid.

  localparam int HCW = $clog2(MAX_HOPS + 1);
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int JN  = 1 << JW;
  localparam int SN  = 1 << SW;
  // Validity masks indexed by the raw id, so out-of-range ids need no comparator.
  localparam logic [JN-1:0] JUNC_OK = JN'((64'd1 << NUM_JUNC) - 64'd1);
  localparam logic [SN-1:0] SLOT_OK = SN'((64'd1 << NUM_SLOTS) - 64'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   table_q [NUM_SLOTS];
  logic [PW-1:0]   path_q, path_d;
  logic [HCW-1:0]  hop_q, hop_d, nxt_idx;
  logic [1:0]      head_q, head_d, new_head;
  logic [DCW-1:0]  dwell_q, dwell_d;
  logic            err_q, err_d;
  logic [HW-1:0]   hop_field [MAX_HOPS+1];
  logic [HW-1:0]   cur_hop, nxt_hop, req_hop0;
  logic [PW-1:0]   req_path;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) table_q[i] <= '0;
    end else if (cfg_we && SLOT_OK[cfg_slot]) begin
      table_q[cfg_slot] <= cfg_path;
    end
  end

  // An extra always-empty hop past the end lets the lookahead read one slot beyond the route.
  always_comb begin
    for (int k = 0; k < MAX_HOPS; k++) hop_field[k] = path_q[k*HW +: HW];
    hop_field[MAX_HOPS] = '0;
  end

  assign nxt_idx  = hop_q + HCW'(1);
  assign cur_hop  = hop_field[hop_q];
  assign nxt_hop  = hop_field[nxt_idx];
  assign req_path = table_q[req_slot];
  assign req_hop0 = req_path[HW-1:0];

  // Heading codes N=00, W=01, E=10, S=11; turn codes 01 left, 10 right, 11 straight.
  always_comb begin
    new_head = head_q;
    case (cur_hop[1:0])
      2'b01: case (head_q)
        2'b00: new_head = 2'b01;
        2'b01: new_head = 2'b11;
        2'b11: new_head = 2'b10;
        default: new_head = 2'b00;
      endcase
      2'b10: case (head_q)
        2'b00: new_head = 2'b10;
        2'b10: new_head = 2'b11;
        2'b11: new_head = 2'b01;
        default: new_head = 2'b00;
      endcase
      default: new_head = head_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      path_q  <= '0;
      hop_q   <= '0;
      head_q  <= '0;
      dwell_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      hop_q   <= hop_d;
      head_q  <= head_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    hop_d   = hop_q;
    head_d  = head_q;
    dwell_d = dwell_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!SLOT_OK[req_slot] || req_hop0[1:0] == 2'b00 || !JUNC_OK[req_hop0[HW-1:2]]) begin
            err_d = 1'b1;
          end else begin
            path_d  = req_path;
            hop_d   = '0;
            head_d  = 2'b00;
            dwell_d = '0;
            state_d = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (dwell_q == DCW'(DWELL - 1)) begin
          dwell_d = '0;
          if (hop_q == HCW'(MAX_HOPS - 1) || nxt_hop[1:0] == 2'b00) begin
            state_d = ST_DONE;
          end else if (!JUNC_OK[nxt_hop[HW-1:2]]) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            hop_d  = nxt_idx;
            head_d = new_head;
          end
        end else begin
          dwell_d = dwell_q + DCW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHOW);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign lamps     = busy ? (LW'(1) << {cur_hop[HW-1:2], new_head}) : '0;

endmodule

// File: tb/tb_parking_route_sequencer.sv
// Bench for parking_route_sequencer: directed scenarios plus random routes checked
// cycle by cycle against a heading-angle reference model.
module tb_parking_route_sequencer;

  localparam int NUM_SLOTS = 6;
  localparam int NUM_JUNC  = 5;
  localparam int MAX_HOPS  = 4;
  localparam int DWELL     = 4;
  localparam int SW = 3;
  localparam int JW = 3;
  localparam int HW = JW + 2;
  localparam int PW = MAX_HOPS * HW;
  localparam int LW = 4 * NUM_JUNC;
  localparam int OW = LW + 4;

  localparam logic [OW-1:0] IDLE_OBS = OW'(1);
  localparam logic [OW-1:0] ERR_OBS  = OW'(3);
  localparam logic [OW-1:0] DONE_OBS = OW'(4);

  localparam int T_END = 0, T_L = 1, T_R = 2, T_S = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [SW-1:0] cfg_slot;
  logic [PW-1:0] cfg_path;
  logic          req_valid;
  logic [SW-1:0] req_slot;
  logic          req_ready;
  logic          cancel;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] lamps;

  parking_route_sequencer #(
    .NUM_SLOTS(NUM_SLOTS), .NUM_JUNC(NUM_JUNC), .MAX_HOPS(MAX_HOPS), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_path(cfg_path),
    .req_valid(req_valid), .req_slot(req_slot), .req_ready(req_ready), .cancel(cancel),
    .busy(busy), .done(done), .err(err), .lamps(lamps)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] exp_q[$];
  logic [PW-1:0] model_tbl [NUM_SLOTS];
  int checks = 0;
  int passes = 0;
  logic [OW-1:0] obs;
  logic [OW-1:0] e;

  assign obs = {lamps, busy, done, err, req_ready};

  function automatic logic [PW-1:0] mk(input int j0, t0, j1, t1, j2, t2, j3, t3);
    int js[4];
    int ts[4];
    logic [PW-1:0] p;
    js = '{j0, j1, j2, j3};
    ts = '{t0, t1, t2, t3};
    p = '0;
    for (int k = 0; k < MAX_HOPS; k++) p[k*HW +: HW] = {3'(js[k]), 2'(ts[k])};
    return p;
  endfunction

  // Compass angle (N=0, E=90, S=180, W=270) to the lamp index within a junction.
  function automatic int lamp_of(input int angle);
    case (angle)
      0:       return 0;
      90:      return 2;
      180:     return 3;
      default: return 1;
    endcase
  endfunction

  // Expected per-cycle {lamps,busy,done,err,req_ready}, starting the cycle after the transfer.
  task automatic build_trace(input int slot);
    logic [PW-1:0] path;
    logic [LW-1:0] l;
    int angle, junc, turn;
    exp_q.delete();
    if (slot >= NUM_SLOTS) begin
      exp_q.push_back(ERR_OBS);
      exp_q.push_back(IDLE_OBS);
      return;
    end
    path = model_tbl[slot];
    angle = 0;
    for (int k = 0; k < MAX_HOPS; k++) begin
      junc = int'(path[k*HW+2 +: JW]);
      turn = int'(path[k*HW +: 2]);
      if (turn == T_END) begin
        if (k == 0) begin
          exp_q.push_back(ERR_OBS);
          exp_q.push_back(IDLE_OBS);
          return;
        end
        break;
      end
      if (junc >= NUM_JUNC) begin
        exp_q.push_back(ERR_OBS);
        exp_q.push_back(IDLE_OBS);
        return;
      end
      if (turn == T_L) angle = (angle + 270) % 360;
      else if (turn == T_R) angle = (angle + 90) % 360;
      l = '0;
      l[4*junc + lamp_of(angle)] = 1'b1;
      repeat (DWELL) exp_q.push_back({l, 4'b1000});
    end
    exp_q.push_back(DONE_OBS);
    exp_q.push_back(IDLE_OBS);
  endtask

  task automatic write_route(input int slot, input logic [PW-1:0] path);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_slot = SW'(slot);
    cfg_path = path;
    @(negedge clk);
    cfg_we = 1'b0;
    if (slot < NUM_SLOTS) model_tbl[slot] = path;
  endtask

  // Returns at the first negedge after the transfer edge.
  task automatic send_req(input int slot);
    @(negedge clk);
    req_valid = 1'b1;
    req_slot = SW'(slot);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_slot = '0; cfg_path = '0;
    req_valid = 1'b0; req_slot = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) model_tbl[i] = '0;
    checks++;
    if (obs !== IDLE_OBS) $display("FAIL reset_outputs got=%h exp=%h", obs, IDLE_OBS);
    else passes++;
  endtask

  task automatic test_basic_route();
    write_route(2, mk(0, T_S, 1, T_R, 0, T_END, 0, T_END));
    build_trace(2);
    send_req(2);
    checks++;
    if (lamps !== LW'(20'h00001)) $display("FAIL basic_first_lamp got=%h exp=%h", lamps, 20'h00001);
    else passes++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL basic_route cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
  endtask

  task automatic test_all_left();
    write_route(3, mk(0, T_L, 1, T_L, 2, T_L, 3, T_L));
    build_trace(3);
    send_req(3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL all_left cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
  endtask

  task automatic test_bad_slot();
    int slots[2];
    slots = '{7, 4};
    foreach (slots[s]) begin
      build_trace(slots[s]);
      send_req(slots[s]);
      for (int i = 0; exp_q.size() > 0; i++) begin
        if (i > 0) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) $display("FAIL bad_slot slot=%0d cyc=%0d got=%h exp=%h", slots[s], i, obs, e);
        else passes++;
      end
    end
  endtask

  task automatic test_cancel();
    write_route(5, mk(2, T_R, 3, T_S, 4, T_L, 0, T_END));
    build_trace(5);
    send_req(5);
    for (int i = 0; i <= DWELL + 1; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL cancel_pre cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (obs !== IDLE_OBS) $display("FAIL cancel_idle got=%h exp=%h", obs, IDLE_OBS);
    else passes++;
    build_trace(2);
    send_req(2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL cancel_after cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
  endtask

  task automatic test_write_same_cycle();
    logic [PW-1:0] new_path;
    write_route(1, mk(1, T_S, 0, T_END, 0, T_END, 0, T_END));
    new_path = mk(4, T_R, 3, T_R, 2, T_S, 0, T_END);
    build_trace(1);
    @(negedge clk);
    cfg_we = 1'b1; cfg_slot = SW'(1); cfg_path = new_path;
    req_valid = 1'b1; req_slot = SW'(1);
    @(negedge clk);
    cfg_we = 1'b0; req_valid = 1'b0;
    model_tbl[1] = new_path;
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL same_cycle_old cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
    build_trace(1);
    send_req(1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL same_cycle_new cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
  endtask

  task automatic test_bad_junction();
    write_route(0, mk(0, T_S, 5, T_L, 0, T_END, 0, T_END));
    build_trace(0);
    send_req(0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL bad_junction cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_route();
    send_req(3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) model_tbl[i] = '0;
    checks++;
    if (obs !== IDLE_OBS) $display("FAIL reset_mid_outputs got=%h exp=%h", obs, IDLE_OBS);
    else passes++;
    build_trace(3);
    send_req(3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) $display("FAIL reset_mid_table cyc=%0d got=%h exp=%h", i, obs, e);
      else passes++;
    end
  endtask

  task automatic test_random_routes();
    logic [PW-1:0] p;
    int turn, slot;
    for (int n = 0; n < 40; n++) begin
      p = '0;
      for (int k = 0; k < MAX_HOPS; k++) begin
        turn = ($urandom_range(0, 6) == 0) ? T_END : int'($urandom_range(1, 3));
        p[k*HW +: HW] = {3'($urandom_range(0, 5)), 2'(turn)};
      end
      write_route(int'($urandom_range(0, 7)), p);
      slot = int'($urandom_range(0, 7));
      build_trace(slot);
      send_req(slot);
      for (int i = 0; exp_q.size() > 0; i++) begin
        if (i > 0) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) $display("FAIL random n=%0d slot=%0d cyc=%0d got=%h exp=%h", n, slot, i, obs, e);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_all_left();
    test_bad_slot();
    test_cancel();
    test_write_same_cycle();
    test_bad_junction();
    test_reset_mid_route();
    test_random_routes();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
